// File: rtl/hex_seg_driver_if.sv
// Bus between the HEX4_5 pattern source and the seven-segment driver.
// The source supplies the raw pattern and the display controls. The driver
// returns the active-low digit outputs and the pattern-change pulse.
interface hex_seg_driver_if;

   logic [13:0] seg_in;
   logic [1:0]  blink_en;
   logic [3:0]  brightness;
   logic        lamp_test;
   logic [6:0]  HEX4;
   logic [6:0]  HEX5;
   logic        changed;

   // Pattern source side: drives the pattern and controls, observes the digits.
   modport master (
      output seg_in,
      output blink_en,
      output brightness,
      output lamp_test,
      input  HEX4,
      input  HEX5,
      input  changed
   );

   // Driver side: consumes the pattern and controls, produces the digits.
   modport slave (
      input  seg_in,
      input  blink_en,
      input  brightness,
      input  lamp_test,
      output HEX4,
      output HEX5,
      output changed
   );

endinterface

// File: rtl/hex_seg_driver.sv
// Seven-segment driver for the HEX4/HEX5 digit pair.
// It registers the 14-bit pattern and adds three display features: per-digit
// blink, global PWM brightness and lamp test. It also pulses 'changed' for one
// cycle whenever the pattern changes. A pattern change restarts the blink
// timebase so that a new value always appears in its lit phase.
module hex_seg_driver #(
   parameter int TICK_DIV    = 50000,
   parameter int BLINK_TICKS = 250
) (
   input logic            clk,
   input logic            reset,
   hex_seg_driver_if.slave bus
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

   localparam logic [3:0] BRIGHT_FULL = 4'hF;
   localparam logic [6:0] SEG_DARK    = 7'h7F;
   localparam logic [6:0] SEG_ALL_LIT = 7'h00;

   typedef enum logic {
      BLINK_ON  = 1'b0,
      BLINK_OFF = 1'b1
   } blink_state_e;

   // Pattern register and change detection
   logic [13:0] seg_q;
   logic [13:0] seg_d;
   logic        changed_q;
   logic        changed_d;
   logic        restart;

   // Timebase prescaler
   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;
   logic             tick;

   // Blink phase
   blink_state_e     state_q;
   blink_state_e     state_d;
   logic [BLK_W-1:0] blk_cnt_q;
   logic [BLK_W-1:0] blk_cnt_d;

   // Brightness modulation
   logic [3:0] pwm_cnt_q;
   logic [3:0] pwm_cnt_d;
   logic       pwm_on;
   logic [1:0] digit_en;

   // Output register
   logic [6:0] hex4_q;
   logic [6:0] hex4_d;
   logic [6:0] hex5_q;
   logic [6:0] hex5_d;

   // Capture the pattern every cycle and flag any difference from the held copy.
   always_comb begin
      seg_d     = bus.seg_in;
      restart   = (bus.seg_in != seg_q);
      changed_d = restart;
   end

   // Free-running tick divider. A restart realigns it so that a full blink
   // half-period elapses after every new pattern.
   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q + DIV_W'(1);
      if (restart || tick) begin
         div_cnt_d = '0;
      end
   end

   // Blink phase machine. A restart wins over a tick in the same cycle.
   always_comb begin
      state_d   = state_q;
      blk_cnt_d = blk_cnt_q;
      if (restart) begin
         state_d   = BLINK_ON;
         blk_cnt_d = '0;
      end else if (tick) begin
         if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            state_d   = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
         end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
         end
      end
   end

   // 16-step brightness modulation. Full brightness bypasses the comparison so
   // that level 15 never has a dark cycle.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 4'd1;
      pwm_on    = (bus.brightness == BRIGHT_FULL) || (pwm_cnt_q < bus.brightness);
   end

   // Digit enables combine brightness with each digit's own blink request.
   always_comb begin
      digit_en[0] = pwm_on && (!bus.blink_en[0] || (state_q == BLINK_ON));
      digit_en[1] = pwm_on && (!bus.blink_en[1] || (state_q == BLINK_ON));
   end

   // Next active-low digit values. Lamp test lights every segment regardless of
   // blink and brightness, and it leaves the counters running.
   always_comb begin
      hex4_d = ~(seg_q[6:0]  & {7{digit_en[0]}});
      hex5_d = ~(seg_q[13:7] & {7{digit_en[1]}});
      if (bus.lamp_test) begin
         hex4_d = SEG_ALL_LIT;
         hex5_d = SEG_ALL_LIT;
      end
   end

   // State and output registers. Reset clears them to a dark display.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q     <= '0;
         changed_q <= 1'b0;
         div_cnt_q <= '0;
         state_q   <= BLINK_ON;
         blk_cnt_q <= '0;
         pwm_cnt_q <= '0;
         hex4_q    <= SEG_DARK;
         hex5_q    <= SEG_DARK;
      end else begin
         seg_q     <= seg_d;
         changed_q <= changed_d;
         div_cnt_q <= div_cnt_d;
         state_q   <= state_d;
         blk_cnt_q <= blk_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         hex4_q    <= hex4_d;
         hex5_q    <= hex5_d;
      end
   end

   assign bus.HEX4    = hex4_q;
   assign bus.HEX5    = hex5_q;
   assign bus.changed = changed_q;

endmodule

// File: doc/hex_seg_driver.md
# hex_seg_driver

Display-side driver for the HEX4/HEX5 seven-segment pair. It consumes the 14-bit segment pattern produced by the HEX4_5 parallel output port and drives the two active-low seven-segment digit outputs. It adds three features on top of the raw pattern: per-digit blink, global PWM brightness, and lamp test. It also emits a one-cycle pulse whenever the pattern changes.

## Interface
Parameters:
- TICK_DIV, default 50000: clk cycles per timebase tick (1 kHz at 50 MHz); must be ≥ 2.
- BLINK_TICKS, default 250: ticks per blink half-period; must be ≥ 1.

Ports:
- clk, input, 1: system clock. Single clock domain; all logic uses the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- seg_in, input, 14: segment pattern; 1 = segment lit. Bits [6:0] = HEX4 segs a..g, bits [13:7] = HEX5 segs a..g. Synchronous to clk.
- blink_en, input, 2: bit 0 blinks HEX4, bit 1 blinks HEX5.
- brightness, input, 4: PWM duty control. 0 = dark, 15 = fully on.
- lamp_test, input, 1: forces all 14 segments lit.
- HEX4, output, 7: digit 4 segments, active-low (0 = lit).
- HEX5, output, 7: digit 5 segments, active-low.
- changed, output, 1: one-cycle pulse on each new pattern.

## Operation
- Input register: seg_q <= seg_in every clk.
- Change detect: changed <= (seg_in != seg_q), registered. It rises at the same edge that seg_q takes the new value.
- Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps. tick = 1 for the one cycle where div_cnt == TICK_DIV-1.
- Blink state machine, two states:
  - States are ON and OFF; a blk_cnt counts 0..BLINK_TICKS-1.
  - On tick with blk_cnt == BLINK_TICKS-1: blk_cnt <= 0 and the state toggles. Otherwise, on tick: blk_cnt <= blk_cnt+1.
  - Restart: when (seg_in != seg_q), blk_cnt <= 0, div_cnt <= 0, state <= ON. This makes a new pattern visible immediately. Restart has priority over tick in the same cycle.
- PWM: pwm_cnt (4 bits) increments every clk and wraps 15→0.
  - pwm_on = (brightness == 15) | (pwm_cnt < brightness).
  - brightness 0 → never on. brightness b in 1..14 → duty b/16. brightness 15 → always on.
- Digit enable: en[d] = pwm_on & (~blink_en[d] | state==ON).
- Output register (registered, active-low):
  - HEX4 <= lamp_test ? 7'h00 : ~(seg_q[6:0] & {7{en[0]}}).
  - HEX5 <= lamp_test ? 7'h00 : ~(seg_q[13:7] & {7{en[1]}}).
  - lamp_test overrides blink and PWM. It does not stop or reset any counter.
- Changes on blink_en or brightness take effect at the next output register update. Counters are not reset.

## Timing
- Reset values (asynchronous, while reset = 1):
  - HEX4 = HEX5 = 7'h7F (all segments dark), changed = 0.
  - seg_q = 0, div_cnt = blk_cnt = pwm_cnt = 0, blink state = ON.
- Reset mid-operation: all state returns to the values above immediately. After reset releases, the first tick occurs TICK_DIV cycles after the first clk edge.
- Latency seg_in → HEX: 2 clk edges, with brightness = 15, blink off, lamp_test = 0. New value on seg_in before edge N → seg_q at N, changed = 1 after N, HEX updated after N+1.
- Latency lamp_test, blink_en, brightness → HEX: 1 clk edge.
- changed is exactly one cycle wide for a single step of seg_in. If seg_in changes on consecutive cycles, changed stays high for each of those cycles.
- Blink period: 2 × BLINK_TICKS × TICK_DIV cycles, 50 % duty. The first OFF phase begins BLINK_TICKS × TICK_DIV cycles after reset release or after the last restart.
- PWM period: 16 cycles. The duty boundaries at brightness 0 and 15 are exact, with no glitch cycles.

## Test plan
Run with TICK_DIV=4, BLINK_TICKS=3 unless stated otherwise.
1. Reset and latency:
   - Assert reset mid-run → HEX4 = HEX5 = 7'h7F and changed = 0 with no clock edge.
   - Release reset with brightness = 15, seg_in = 14'h0006 → HEX4 = 7'h79 two edges later, HEX5 = 7'h7F, changed pulses for 1 cycle.
2. Blink:
   - blink_en = 2'b01, seg_in = 14'h3FFF, brightness = 15 → HEX4 alternates 7'h00 / 7'h7F every 12 cycles, starting with 12 cycles lit; HEX5 stays 7'h00.
   - A new seg_in value 5 cycles into the OFF phase → HEX4 lit 2 edges later, and the next OFF comes 12 cycles after the restart.
3. PWM:
   - brightness = 4, blink off, seg_in = 14'h3FFF → HEX4 = 7'h00 for exactly 4 of every 16 cycles.
   - brightness = 0 → always 7'h7F.
   - brightness = 15 → always 7'h00.
4. Lamp test:
   - brightness = 0, blink_en = 2'b11, lamp_test = 1 → HEX4 = HEX5 = 7'h00 one edge later.
   - Deasserting lamp_test resumes the blink phase without a restart; verify the blink counter continued through the lamp test.
5. Simultaneous events: seg_in change in the same cycle as the tick that ends the ON phase → state stays ON, blk_cnt = 0, changed = 1.
6. Back-to-back changes: seg_in changes on 3 consecutive cycles → changed high for 3 cycles; HEX tracks each value with 2-cycle latency.
